// File: rtl/key_conditioner.sv
// Synchronises, debounces and edge-detects raw board inputs, one independent channel per bit.
// Optional auto-repeat of press pulses on held inputs: define KEY_CONDITIONER_AUTOREPEAT_EN.
module key_conditioner #(
    parameter int N_IN            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] press,
    output logic [N_IN-1:0] release_o
);

    localparam logic          POL      = (ACTIVE_LOW != 0);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
        $error("key_conditioner: illegal debounce/repeat configuration");
    end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    localparam int            RW         = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          s;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        logic [RW-1:0] rpt_q, rpt_d;
`endif

        // Polarity-corrected sample: 1 means the input is asserted.
        assign s = sync2_q ^ POL;

        always_comb begin
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d   = s;
                cnt_d     = '0;
                press_d   = s;
                release_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
            // Repeat counter only runs while the level is and stays high; a falling edge wins.
            rpt_d = rpt_q;
            if (!level_q || !level_d) begin
                rpt_d = '0;
            end else if (rpt_q == RPT_LAST) begin
                rpt_d   = RPT_RELOAD;
                press_d = 1'b1;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
`endif
        end

        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                sync1_q   <= POL;
                sync2_q   <= POL;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                cnt_q     <= '0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
                rpt_q     <= '0;
`endif
            end else begin
                sync1_q   <= raw_in[i];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                cnt_q     <= cnt_d;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
                rpt_q     <= rpt_d;
`endif
            end
        end

        assign level[i]     = level_q;
        assign press[i]     = press_q;
        assign release_o[i] = release_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: pulse events are predicted into a queue and
// matched against the DUT by a negedge monitor; level checks are done inline per scenario.
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         resetn;
    logic [N-1:0] raw_in;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_o;

    int unsigned  edge_cnt = 0;
    int           cmp_cnt  = 0;
    int           err_cnt  = 0;
    logic [39:0]  exp_q[$];

    key_conditioner #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .raw_in    (raw_in),
        .level     (level),
        .press     (press),
        .release_o (release_o)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Event word: {edge index after which the pulse is visible, press, release}
    function automatic logic [39:0] ev(int unsigned cyc, logic [3:0] p, logic [3:0] r);
        return {cyc, p, r};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [39:0] obs;
        logic [39:0] expv;
        if (resetn === 1'b1 && (press !== 4'b0 || release_o !== 4'b0)) begin
            obs = {edge_cnt, press, release_o};
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_pulse: got cycle=%0d press=%b release=%b, want no pulse",
                         obs[39:8], obs[7:4], obs[3:0]);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    err_cnt++;
                    $display("FAIL pulse_event: got cycle=%0d press=%b release=%b, want cycle=%0d press=%b release=%b",
                             obs[39:8], obs[7:4], obs[3:0], expv[39:8], expv[7:4], expv[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        raw_in = 4'hF;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        cmp_cnt++;
        if (level !== 4'b0) begin
            err_cnt++; $display("FAIL reset_level: got %b, want 0000", level);
        end
        cmp_cnt++;
        if (press !== 4'b0) begin
            err_cnt++; $display("FAIL reset_press: got %b, want 0000", press);
        end
        cmp_cnt++;
        if (release_o !== 4'b0) begin
            err_cnt++; $display("FAIL reset_release: got %b, want 0000", release_o);
        end
        wait_edges(3);
        resetn = 1'b1;
        wait_edges(10);
        cmp_cnt++;
        if (level !== 4'b0) begin
            err_cnt++; $display("FAIL idle_level: got %b, want 0000", level);
        end
    endtask

    task automatic test_clean_press();
        int unsigned cur;
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0001, 4'b0000));
        raw_in[0] = 1'b0;
        wait_edges(5);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL press_not_early: got %b, want 0000", level);
        end
        wait_edges(1);
        cmp_cnt++;
        if (level !== 4'b0001) begin
            err_cnt++; $display("FAIL press_level: got %b, want 0001", level);
        end
        wait_edges(1);
        cmp_cnt++;
        if (press !== 4'b0000) begin
            err_cnt++; $display("FAIL press_one_cycle: got %b, want 0000", press);
        end
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0000, 4'b0001));
        raw_in[0] = 1'b1;
        wait_edges(5);
        cmp_cnt++;
        if (level !== 4'b0001) begin
            err_cnt++; $display("FAIL release_not_early: got %b, want 0001", level);
        end
        wait_edges(1);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL release_level: got %b, want 0000", level);
        end
        wait_edges(2);
    endtask

    task automatic test_bounce();
        int unsigned cur;
        repeat (5) begin
            raw_in[1] = 1'b0;
            wait_edges(D - 1);
            raw_in[1] = 1'b1;
            wait_edges(1);
        end
        wait_edges(4);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL bounce_rejected: got %b, want 0000", level);
        end
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0010, 4'b0000));
        raw_in[1] = 1'b0;
        wait_edges(8);
        cmp_cnt++;
        if (level !== 4'b0010) begin
            err_cnt++; $display("FAIL bounce_hold_level: got %b, want 0010", level);
        end
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0000, 4'b0010));
        raw_in[1] = 1'b1;
        wait_edges(8);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL bounce_release_level: got %b, want 0000", level);
        end
    endtask

    task automatic test_simultaneous();
        int unsigned cur;
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b1100, 4'b0000));
        raw_in[3:2] = 2'b00;
        wait_edges(8);
        cmp_cnt++;
        if (level !== 4'b1100) begin
            err_cnt++; $display("FAIL simul_press_level: got %b, want 1100", level);
        end
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0000, 4'b1100));
        raw_in[3:2] = 2'b11;
        wait_edges(8);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL simul_release_level: got %b, want 0000", level);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned cur;
        raw_in[0] = 1'b0;
        wait_edges(4);
        #2 resetn = 1'b0;
        #1;
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL midreset_level: got %b, want 0000", level);
        end
        cmp_cnt++;
        if (press !== 4'b0000) begin
            err_cnt++; $display("FAIL midreset_press: got %b, want 0000", press);
        end
        @(negedge clk);
        resetn = 1'b1;
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0001, 4'b0000));
        wait_edges(6);
        cmp_cnt++;
        if (level !== 4'b0001) begin
            err_cnt++; $display("FAIL midreset_repress_level: got %b, want 0001", level);
        end
        cur = edge_cnt;
        exp_q.push_back(ev(cur + 6, 4'b0000, 4'b0001));
        raw_in[0] = 1'b1;
        wait_edges(8);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL midreset_release_level: got %b, want 0000", level);
        end
    endtask

    task automatic test_autorepeat();
        int unsigned a;
        int unsigned r;
        a = edge_cnt + 6;
        r = a + 30;
        exp_q.push_back(ev(a, 4'b0001, 4'b0000));
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        for (int unsigned t = a + RD; t < r; t += RP)
            exp_q.push_back(ev(t, 4'b0001, 4'b0000));
`endif
        exp_q.push_back(ev(r, 4'b0000, 4'b0001));
        raw_in[0] = 1'b0;
        wait_edges(6 + 24);
        raw_in[0] = 1'b1;
        wait_edges(6);
        cmp_cnt++;
        if (level !== 4'b0000) begin
            err_cnt++; $display("FAIL repeat_release_level: got %b, want 0000", level);
        end
        wait_edges(15);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        wait_edges(5);
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL pending_events: got %0d unmatched expected pulses, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
